// File: rtl/gf256_div_seq.sv
// Sequential GF(2^8) divider: quotient = dividend * divisor^254 via square-and-multiply.
// Optional macro GF_DIV_ZERO_FASTPATH_EN: a zero divisor goes straight to DONE on the accept edge.
module gf256_div_seq #(
    parameter logic [7:0] POLY = 8'h1D,
    parameter int         ITER = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] quotient,
    output logic       div_zero
);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FINAL, S_DONE} state_t;

    localparam logic [2:0] CNT_LAST = 3'(ITER - 1);

    // Carry-less 8x8 product, then fold bits 14..8 back down with {1,POLY}.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ (15'(x) << i);
        end
        for (int i = 14; i >= 8; i--) begin
            if (p[i]) p = p ^ (15'({1'b1, POLY}) << (i - 8));
        end
        return p[7:0];
    endfunction

    state_t     state_q;
    logic       in_ready_q;
    logic       out_valid_q;
    logic [7:0] quotient_q;
    logic       div_zero_q;
    logic [7:0] a_q;
    logic [7:0] sq_q;
    logic [7:0] acc_q;
    logic [2:0] cnt_q;
    logic       zero_q;

    logic [7:0] sq2_d;
    logic [7:0] acc_d;
    logic [7:0] quo_d;

    always_comb begin
        sq2_d = gf_mul(sq_q, sq_q);
        acc_d = gf_mul(acc_q, sq2_d);
        quo_d = gf_mul(acc_q, a_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= 8'h00;
            div_zero_q  <= 1'b0;
            a_q         <= 8'h00;
            sq_q        <= 8'h00;
            acc_q       <= 8'h00;
            cnt_q       <= 3'd0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= dividend;
                        sq_q       <= divisor;
                        acc_q      <= 8'h01;
                        cnt_q      <= 3'd0;
                        zero_q     <= (divisor == 8'h00);
                        in_ready_q <= 1'b0;
`ifdef GF_DIV_ZERO_FASTPATH_EN
                        if (divisor == 8'h00) begin
                            quotient_q  <= 8'h00;
                            div_zero_q  <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            state_q <= S_ITER;
                        end
`else
                        state_q <= S_ITER;
`endif
                    end
                end
                // acc accumulates divisor^(2+4+...+128) = divisor^254 = divisor^-1
                S_ITER: begin
                    sq_q  <= sq2_d;
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == CNT_LAST) state_q <= S_FINAL;
                end
                S_FINAL: begin
                    quotient_q  <= quo_d;
                    div_zero_q  <= zero_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_gf256_div_seq.sv
// Scoreboard bench for gf256_div_seq: directed spec vectors, backpressure, mid-run reset, random pairs.
module tb_gf256_div_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic       div_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic       z;
    } exp_t;

    exp_t sb[$];
    exp_t me;

`ifdef GF_DIV_ZERO_FASTPATH_EN
    localparam int ZLAT = 0;
`else
    localparam int ZLAT = 8;
`endif

    gf256_div_seq dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dividend (dividend),
        .divisor  (divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient (quotient),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Shift-and-add field multiply, reducing by x^8+x^4+x^3+x^2+1 after each shift.
    function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r;
        logic [7:0] t;
        r = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) r = r ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1D : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [7:0] ref_div(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] q;
        if (b == 8'h00) return 8'h00;
        for (int k = 0; k < 256; k++) begin
            q = 8'(k);
            if (ref_mul(q, b) == a) return q;
        end
        return 8'h00;
    endfunction

    always @(negedge clk) begin
        #1;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_pop", 32'(sb.size()), 32'd1);
            end else begin
                me = sb.pop_front();
                chk("quotient", 32'(quotient), 32'(me.q));
                chk("div_zero", 32'(div_zero), 32'(me.z));
                if (me.b != 8'h00) chk("q_times_b", 32'(ref_mul(quotient, me.b)), 32'(me.a));
            end
        end
    end

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_q,
                         input bit hold);
        int   n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        e.a = a;
        e.b = b;
        e.q = exp_q;
        e.z = (b == 8'h00);
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'((b == 8'h00) ? ZLAT : 8));
        if (hold) begin
            repeat (20) begin
                @(negedge clk);
                in_valid = 1'($urandom);
                dividend = 8'($urandom);
                divisor  = 8'($urandom);
                chk("hold_q", 32'(quotient), 32'(e.q));
                chk("hold_z", 32'(div_zero), 32'(e.z));
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_in_ready", 32'(in_ready), 32'd0);
            end
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = 8'h00;
        divisor   = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_z", 32'(div_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(8'h01, 8'h02, 8'h8E, 1'b0);
        do_op(8'h1D, 8'h02, 8'h80, 1'b0);
        do_op(8'h02, 8'h02, 8'h01, 1'b0);
        do_op(8'h00, 8'h02, 8'h00, 1'b0);
        do_op(8'h53, 8'h00, 8'h00, 1'b0);
        do_op(8'h53, 8'h01, 8'h53, 1'b0);

        out_ready = 1'b0;
        do_op(8'h53, 8'h07, ref_div(8'h53, 8'h07), 1'b1);

        // Abort a computation in its 4th ITER cycle; nothing is pushed for it.
        in_valid = 1'b1;
        dividend = 8'h37;
        divisor  = 8'h05;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_q", 32'(quotient), 32'd0);
        chk("midrst_z", 32'(div_zero), 32'd0);
        do_op(8'h37, 8'h05, ref_div(8'h37, 8'h05), 1'b0);

        for (int i = 0; i < 2000; i++) begin
            rb = (i % 97 == 0) ? 8'h00 : 8'($urandom_range(255, 1));
            ra = (i % 16 == 0) ? 8'h00 : 8'($urandom);
            do_op(ra, rb, ref_div(ra, rb), 1'b0);
        end

        repeat (2) @(negedge clk);
        chk("sb_leftover", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
